load_store_unit: RTL and testbench

Initiator for the word-organised data memory: accepts one load or store request at a time from the execute stage, translates byte address and RV32I width/sign (funct3) into word-granular memory transactions, and returns aligned, sign- or zero-extended load data. Byte and halfword stores are performed as read-modify-write, because the memory only writes whole words. Sits between the core's memory stage and the data memory, driving the memory's `MemRead`/`MemWrite`/`Address`/`Write_data` and sampling `Read_data`.

---
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: word-memory initiator for RV32I loads/stores; sub-word stores as read-modify-write.
// Ports: clk, reset, req_* (request), resp_* (completion), MemRead/MemWrite/Address/Write_data/Read_data (memory). Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state, nxt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] word_q;
   logic [31:0] addr_q;

   logic        f3_bad;
   logic        mis;
   logic        req_err;
   logic [31:0] wr_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      f3_bad = req_we ? (req_funct3 > 3'd2)
                      : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_funct3[1:0] == 2'd1)
         mis = req_addr[0];
      else if (req_funct3[1:0] == 2'd2)
         mis = (req_addr[1:0] != 2'b00);
`endif
      req_err = f3_bad | mis;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  nxt = DONE;
               else if (req_we && req_funct3 == 3'd2)
                  nxt = WR;
               else
                  nxt = RD;
            end
         end
         RD:      nxt = we_q ? WR : DONE;
         WR:      nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         lo_q    <= 2'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         word_q  <= 32'd0;
         addr_q  <= 32'd0;
      end else begin
         state <= nxt;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            lo_q    <= req_addr[1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            addr_q  <= {2'b00, req_addr[31:2]};
         end
         if (state == RD)
            word_q <= Read_data;
      end
   end

   // Merge store data into the captured word; SW ignores the capture.
   always_comb begin
      wr_word = word_q;
      unique case (f3_q[1:0])
         2'd0:    wr_word[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
         2'd1:    wr_word[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: wr_word = wdata_q;
      endcase
   end

   always_comb begin
      ld_byte = word_q[{lo_q, 3'b000} +: 8];
      ld_half = word_q[{lo_q[1], 4'b0000} +: 16];
      ld_ext  = 32'd0;
      unique case (1'b1)
         (f3_q[1:0] == 2'd2):
            ld_ext = word_q;
         (f3_q[1:0] == 2'd1):
            ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
         default:
            ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      endcase
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign resp_err   = (state == DONE) & err_q;
   assign resp_rdata = (state == DONE && !we_q && !err_q) ? ld_ext : 32'd0;
   assign MemRead    = (state == RD);
   assign MemWrite   = (state == WR);
   assign Address    = addr_q;
   assign Write_data = (state == WR) ? wr_word : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random + directed checks of load_store_unit against a byte-array memory model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [31:0] Read_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:63];
   logic        mem_load;
   logic [7:0]  ref_b [0:255];

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data)
   );

   function automatic logic [31:0] seed_word(int i);
      return (32'h1357_9BDF * (i + 1)) ^ 32'hA5A5_0F0F;
   endfunction

   assign Read_data = mem[Address[5:0]];

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
      end else if (MemWrite) begin
         mem[Address[5:0]] <= Write_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] got_rd, output logic [31:0] got_wd);
      bit          illegal, mis, eerr, seen;
      int          size, base, elat, ereads, ewrites;
      int          lat, reads, writes, overlap;
      logic [31:0] erd, ewd, v;
      logic        gerr;
      illegal = we ? (f3 > 2) : (f3 == 3 || f3 > 5);
      mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'd1 && addr[0]) mis = 1;
      if (f3[1:0] == 2'd2 && addr[1:0] != 0) mis = 1;
`endif
      eerr = illegal | mis;
      size = 1 << f3[1:0];
      base = int'(addr) & ~(size - 1);
      erd = 0;
      ewd = 0;
      if (!eerr && !we) begin
         v = 0;
         for (int b = 0; b < size; b++)
            v = v | (32'(ref_b[base + b]) << (8 * b));
         if (!f3[2] && size < 4 && v[8 * size - 1])
            v = v | (32'hFFFF_FFFF << (8 * size));
         erd = v;
      end
      if (!eerr && we) begin
         for (int b = 0; b < size; b++)
            ref_b[base + b] = wdata[8 * b +: 8];
         for (int b = 0; b < 4; b++)
            ewd[8 * b +: 8] = ref_b[(base & ~3) + b];
      end
      elat    = eerr ? 1 : ((we && size != 4) ? 3 : 2);
      ereads  = eerr ? 0 : ((we && size == 4) ? 0 : 1);
      ewrites = (eerr || !we) ? 0 : 1;

      @(negedge clk);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("single_pulse", {31'd0, resp_valid}, 32'd0);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0; lat = 0; reads = 0; writes = 0; overlap = 0;
      gerr = 0; got_rd = 0; got_wd = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (MemRead && MemWrite) overlap++;
         if (MemRead) begin
            reads++;
            check("rd_addr", Address, 32'(base >> 2));
         end
         if (MemWrite) begin
            writes++;
            got_wd = Write_data;
            check("wr_addr", Address, 32'(base >> 2));
         end
         if (resp_valid) begin
            seen = 1; lat = n; got_rd = resp_rdata; gerr = resp_err;
            break;
         end
         check("busy_ready", {31'd0, req_ready}, 32'd0);
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL timeout: no resp_valid f3=%0d we=%0d", f3, we);
      end else begin
         check("latency", lat, elat);
         check("err", {31'd0, gerr}, {31'd0, eerr});
         check("rdata", got_rd, erd);
         check("reads", reads, ereads);
         check("writes", writes, ewrites);
         check("overlap", overlap, 0);
         if (ewrites != 0) check("wdata", got_wd, ewd);
      end
   endtask

   task automatic reset_abort();
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd1;
      req_addr   = 32'h20;
      req_wdata  = 32'h0000_BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("abort_in_rd", {31'd0, MemRead}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (n == 0) begin
            check("abort_ready", {31'd0, req_ready}, 32'd1);
            check("abort_addr", Address, 32'd0);
         end
         check("abort_nowrite", {31'd0, MemWrite}, 32'd0);
         check("abort_noresp", {31'd0, resp_valid}, 32'd0);
      end
   endtask

   logic [31:0] rd, wd;

   initial begin
      reset      = 1'b1;
      mem_load   = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      for (int i = 0; i < 64; i++)
         for (int b = 0; b < 4; b++)
            ref_b[4 * i + b] = seed_word(i) >> (8 * b);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_memrd", {31'd0, MemRead}, 32'd0);
      check("rst_memwr", {31'd0, MemWrite}, 32'd0);
      check("rst_addr", Address, 32'd0);
      check("rst_wdata", Write_data, 32'd0);
      reset    = 1'b0;
      mem_load = 1'b0;

      run(1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, wd);
      check("sw_word", wd, 32'hDEAD_BEEF);
      run(0, 3'd2, 32'h10, 32'd0, rd, wd);
      check("lw_word", rd, 32'hDEAD_BEEF);
      run(1, 3'd0, 32'h11, 32'h55, rd, wd);
      check("sb_merge", wd, 32'hDEAD_55EF);
      run(0, 3'd4, 32'h11, 32'd0, rd, wd);
      check("lbu", rd, 32'h0000_0055);
      run(0, 3'd0, 32'h13, 32'd0, rd, wd);
      check("lb", rd, 32'hFFFF_FFDE);
      run(0, 3'd5, 32'h12, 32'd0, rd, wd);
      check("lhu", rd, 32'h0000_DEAD);
      run(0, 3'd1, 32'h10, 32'd0, rd, wd);
      check("lh", rd, 32'h0000_55EF);
      run(0, 3'd2, 32'h12, 32'd0, rd, wd);
`ifndef LSU_MISALIGN_TRAP_EN
      check("lw_mis", rd, 32'hDEAD_55EF);
`endif
      run(0, 3'd3, 32'h10, 32'd0, rd, wd);
      run(1, 3'd4, 32'h10, 32'h1234, rd, wd);

      reset_abort();
      run(0, 3'd2, 32'h20, 32'd0, rd, wd);

      for (int i = 0; i < 300; i++)
         run(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, rd, wd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
